// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and constants for the programmable serial pattern detector.
//   len_w()     : width of a length field able to hold 0..max_len
//   fill_w()    : width of the history fill counter (holds 0..max_len-1)
//   DEF_*       : power-on configuration (the legacy "11001" detector, overlapping)
//   seq_cfg_t   : runtime configuration record. Fields are sized for the largest
//                 supported pattern (CFG_MAX_LEN); a detector instance only uses
//                 the low MAX_LEN / LEN_W bits.
// Optional feature: SEQ_DET_MASK_EN adds a per-bit compare mask to seq_cfg_t.
package seq_det_pkg;

  localparam int CFG_MAX_LEN = 32;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int fill_w(input int max_len);
    return $clog2(max_len);
  endfunction

  localparam int CFG_LEN_W = len_w(CFG_MAX_LEN);

  localparam logic [CFG_MAX_LEN-1:0] DEF_PATTERN = 32'b0001_1001;
  localparam int                     DEF_LEN     = 5;
  localparam bit                     DEF_OVERLAP = 1'b1;

  typedef struct packed {
    logic [CFG_MAX_LEN-1:0] pattern;
    logic [CFG_LEN_W-1:0]   len;
    logic                   overlap;
`ifdef SEQ_DET_MASK_EN
    logic [CFG_MAX_LEN-1:0] mask;
`endif
  } seq_cfg_t;

endpackage

// File: rtl/seq_det_if.sv
// seq_det_if: serial stream, configuration and result signals of seq_det_prog.
//   master : stream/config producer (drives in_*, cfg_*, cnt_clr; reads results)
//   slave  : the detector
// Optional feature: SEQ_DET_MASK_EN adds cfg_mask.
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = len_w(MAX_LEN);

  logic               in_valid;
  logic               in_bit;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
`ifdef SEQ_DET_MASK_EN
  logic [MAX_LEN-1:0] cfg_mask;
`endif
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
`ifdef SEQ_DET_MASK_EN
    output cfg_mask,
`endif
    output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  match, match_cnt, cfg_err
  );

  modport slave (
`ifdef SEQ_DET_MASK_EN
    input  cfg_mask,
`endif
    input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output match, match_cnt, cfg_err
  );

endinterface

// File: rtl/seq_det_window.sv
// seq_det_window: history shifter and fill counter of the pattern detector.
//   clk, rst : clock, synchronous active-high reset
//   shift_en : consume in_bit this cycle (already excludes config-load cycles)
//   in_bit   : serial data bit
//   clr      : accepted configuration load -> empty history
//   restart  : non-overlapping match on this bit -> start a fresh window
//   hist     : previously consumed bits, hist[0] most recent
//   fill     : number of valid history bits, saturating at MAX_LEN-1
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  localparam int FILL_W = fill_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               in_bit,
  input  logic               clr,
  input  logic               restart,
  output logic [MAX_LEN-2:0] hist,
  output logic [FILL_W-1:0]  fill
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);

  logic [MAX_LEN-2:0] hist_reg, hist_next;
  logic [FILL_W-1:0]  fill_reg, fill_next;

  generate
    if (MAX_LEN == 2) begin : g_hist_one
      assign hist_next = in_bit;
    end else begin : g_hist_shift
      assign hist_next = {hist_reg[MAX_LEN-3:0], in_bit};
    end
  endgenerate

  // A restart only zeroes fill: the stale history bits are masked out by the
  // fill check until they have all been replaced by fresh ones.
  always_comb begin
    fill_next = fill_reg;
    if (restart)
      fill_next = '0;
    else if (fill_reg != FILL_MAX)
      fill_next = fill_reg + FILL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (shift_en) begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
    end
  end

  assign hist = hist_reg;
  assign fill = fill_reg;

endmodule

// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial pattern detector (Mealy output).
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : in_valid/in_bit stream, cfg_load/cfg_pattern/cfg_len/
//                   cfg_overlap configuration, cnt_clr, and the results
//                   match (combinational), match_cnt (saturating), cfg_err
//                   (one-cycle pulse after a rejected load).
// Pattern bit [len-1] is the first received bit, bit [0] the last, so the
// current in_bit always lines up with pattern[0].
// Optional feature: define SEQ_DET_MASK_EN to add cfg_mask (1 = compare bit).
// MAX_LEN must lie in 2..CFG_MAX_LEN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int                     MAX_LEN     = 8,
  parameter int                     CNT_W       = 16,
  parameter logic [CFG_MAX_LEN-1:0] RST_PATTERN = DEF_PATTERN,
  parameter int                     RST_LEN     = DEF_LEN,
  parameter bit                     RST_OVERLAP = DEF_OVERLAP
) (
  input  logic      clk,
  input  logic      rst,
  seq_det_if.slave  bus
);

  localparam int LEN_W  = len_w(MAX_LEN);
  localparam int FILL_W = fill_w(MAX_LEN);

  seq_cfg_t           cfg_reg;
  logic               cfg_unused;
  logic [LEN_W-1:0]   cur_len;
  logic               cfg_len_ok;
  logic [MAX_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] bit_ok;
  logic               fill_ok;
  logic               match_now;
  logic [CNT_W-1:0]   match_cnt_reg;
  logic               cfg_err_reg;

  assign cfg_len_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

  // Configuration register; bits above MAX_LEN / LEN_W stay zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_reg.pattern <= CFG_MAX_LEN'(RST_PATTERN[MAX_LEN-1:0]);
      cfg_reg.len     <= CFG_LEN_W'(RST_LEN);
      cfg_reg.overlap <= RST_OVERLAP;
`ifdef SEQ_DET_MASK_EN
      cfg_reg.mask    <= CFG_MAX_LEN'({MAX_LEN{1'b1}});
`endif
    end else if (bus.cfg_load && cfg_len_ok) begin
      cfg_reg.pattern <= CFG_MAX_LEN'(bus.cfg_pattern);
      cfg_reg.len     <= CFG_LEN_W'(bus.cfg_len);
      cfg_reg.overlap <= bus.cfg_overlap;
`ifdef SEQ_DET_MASK_EN
      cfg_reg.mask    <= CFG_MAX_LEN'(bus.cfg_mask);
`endif
    end
  end

  // The upper, never-used bits of the wide config record are folded here.
  assign cfg_unused = ^cfg_reg;
  assign cur_len    = cfg_reg.len[LEN_W-1:0];

  seq_det_window #(
    .MAX_LEN (MAX_LEN)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (bus.in_valid & ~bus.cfg_load),
    .in_bit   (bus.in_bit),
    .clr      (bus.cfg_load & cfg_len_ok),
    .restart  (match_now & ~cfg_reg.overlap),
    .hist     (hist),
    .fill     (fill)
  );

  // Candidate window: the current bit followed by the history, oldest on top.
  assign window = {hist, bus.in_bit};

  // Positions at or above len are don't-care, which makes len==1 reduce to a
  // plain compare of in_bit against pattern[0].
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
`ifdef SEQ_DET_MASK_EN
      assign bit_ok[gi] = (LEN_W'(gi) >= cur_len) || !cfg_reg.mask[gi] ||
                          (window[gi] == cfg_reg.pattern[gi]);
`else
      assign bit_ok[gi] = (LEN_W'(gi) >= cur_len) ||
                          (window[gi] == cfg_reg.pattern[gi]);
`endif
    end
  endgenerate

  // cur_len is never 0, so len-1 cannot wrap.
  assign fill_ok   = LEN_W'(fill) >= (cur_len - LEN_W'(1));
  assign match_now = bus.in_valid & ~bus.cfg_load & ~rst & fill_ok & (&bit_ok);

  always_ff @(posedge clk) begin
    if (rst || bus.cnt_clr)
      match_cnt_reg <= '0;
    else if (match_now && (match_cnt_reg != {CNT_W{1'b1}}))
      match_cnt_reg <= match_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cfg_err_reg <= 1'b0;
    else
      cfg_err_reg <= bus.cfg_load & ~cfg_len_ok;
  end

  assign bus.match     = match_now;
  assign bus.match_cnt = match_cnt_reg;
  assign bus.cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed test of seq_det_prog with a queue-based reference
// model checked every cycle, plus hand-computed match/count expectations.
// Built with MAX_LEN=8 and CNT_W=4 so counter saturation is reachable.
module tb_seq_det_prog;
  import seq_det_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 4;
  localparam int LEN_W   = len_w(MAX_LEN);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_det_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_det_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bits consumed since the last clear/restart are kept
  // in a queue; a match is read straight off the tail of that queue.
  bit [MAX_LEN-1:0] m_pat;
  bit [MAX_LEN-1:0] m_mask;
  int               m_len;
  bit               m_ovl;
  bit               seen[$];
  int               m_cnt;
  bit               m_err;

  function automatic bit model_hit(input bit b);
    bit w;
    if (seen.size() < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      w = (k == 0) ? b : seen[seen.size() - k];
      if (m_mask[k] && (w != m_pat[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    bit exp_m;
    exp_m = !rst && bus.in_valid && !bus.cfg_load && model_hit(bus.in_bit);
    if (checking) begin
      chk("cyc_match", bus.match, exp_m);
      chk("cyc_cnt", bus.match_cnt, m_cnt);
      chk("cyc_err", bus.cfg_err, m_err);
    end
    // Advance the model to the state after the coming rising edge.
    if (rst) begin
      m_pat  = 8'b0001_1001;
      m_len  = 5;
      m_ovl  = 1'b1;
      m_mask = '1;
      seen.delete();
      m_cnt  = 0;
      m_err  = 1'b0;
    end else begin
      m_err = bus.cfg_load && !(bus.cfg_len >= 1 && bus.cfg_len <= MAX_LEN);
      if (bus.cnt_clr) m_cnt = 0;
      else if (exp_m && m_cnt < CNT_MAX) m_cnt++;
      if (bus.cfg_load) begin
        if (!m_err) begin
          m_pat = bus.cfg_pattern;
          m_len = int'(bus.cfg_len);
          m_ovl = bus.cfg_overlap;
`ifdef SEQ_DET_MASK_EN
          m_mask = bus.cfg_mask;
`endif
          seen.delete();
        end
      end else if (bus.in_valid) begin
        if (exp_m && !m_ovl) seen.delete();
        else begin
          seen.push_back(bus.in_bit);
          if (seen.size() > MAX_LEN) void'(seen.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit v, input bit b, input bit ld, input bit clr,
                     input bit exp_m, input string name);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.cfg_load = ld;
    bus.cnt_clr  = clr;
    @(negedge clk);
    chk(name, bus.match, exp_m);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_match");
  endtask

  // bits are sent MSB first; hits bit i is the expected match on bit index i.
  task automatic feed(input logic [31:0] bits, input int n, input logic [31:0] hits,
                      input string name);
    for (int i = 0; i < n; i++)
      cyc(1'b1, bits[n-1-i], 1'b0, 1'b0, hits[i], name);
  endtask

  task automatic set_cfg(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl,
                         input logic [MAX_LEN-1:0] mask);
    bus.cfg_pattern = pat;
    bus.cfg_len     = LEN_W'(len);
    bus.cfg_overlap = ovl;
`ifdef SEQ_DET_MASK_EN
    bus.cfg_mask    = mask;
`else
    if (mask == '0) bus.cfg_overlap = ovl;
`endif
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl,
                      input logic [MAX_LEN-1:0] mask, input bit exp_err);
    @(posedge clk);
    #1;
    set_cfg(pat, len, ovl, mask);
    bus.cfg_load = 1'b1;
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b0;
    @(negedge clk);
    chk("load_match", bus.match, 1'b0);
    @(posedge clk);
    #1;
    bus.cfg_load = 1'b0;
    @(negedge clk);
    chk("load_err", bus.cfg_err, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] s5;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.cfg_load = 1'b0;
    bus.cnt_clr  = 1'b0;
    set_cfg('0, 0, 1'b0, '1);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("rst_match", bus.match, 1'b0);
    chk("rst_cnt", bus.match_cnt, 0);
    chk("rst_err", bus.cfg_err, 1'b0);

    // Default 11001 detector.
    feed(32'b11001, 5, 32'h10, "dflt");
    idle();
    chk("dflt_cnt", bus.match_cnt, 1);

    // 1010 with and without overlap; reload keeps the count.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");
    load(8'b1010, 4, 1'b1, '1, 1'b0);
    feed(32'b1010101010, 10, 32'h2A8, "ovl1");
    idle();
    chk("ovl1_cnt", bus.match_cnt, 4);
    load(8'b1010, 4, 1'b0, '1, 1'b0);
    feed(32'b1010101010, 10, 32'h088, "ovl0");
    idle();
    chk("ovl0_cnt", bus.match_cnt, 6);

    // Valid gaps: in_bit=1 during gaps must not be consumed.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");
    load(8'b11001, 5, 1'b1, '1, 1'b0);
    s5 = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, s5[4-i], 1'b0, 1'b0, (i == 4), "gap_bit");
      repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "gap_idle");
    end
    idle();
    chk("gap_cnt", bus.match_cnt, 1);

    // Rejected loads leave the 11001 detector intact.
    load(8'hFF, 0, 1'b0, '0, 1'b1);
    load(8'hFF, MAX_LEN + 1, 1'b0, '0, 1'b1);
    feed(32'b11001, 5, 32'h10, "after_bad");
    idle();
    chk("bad_cnt", bus.match_cnt, 2);

    // Load on the completing bit: bit discarded, history cleared.
    feed(32'b1100, 4, 32'h0, "pre_sim");
    set_cfg(8'b11001, 5, 1'b1, '1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "sim_load");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sim_after");
    idle();
    chk("sim_cnt", bus.match_cnt, 2);

    // len==1, saturation, clear beats increment.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr");
    load(8'b1, 1, 1'b1, '1, 1'b0);
    repeat (15) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "len1_hit");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "len1_miss");
    idle();
    chk("sat_cnt", bus.match_cnt, 15);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "sat_hit");
    idle();
    chk("sat_hold", bus.match_cnt, 15);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "clr_hit");
    idle();
    chk("clr_cnt", bus.match_cnt, 0);

    // Reset mid-pattern restores defaults and restarts fill.
    load(8'b11001, 5, 1'b1, '1, 1'b0);
    feed(32'b1100, 4, 32'h0, "pre_rst");
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    @(negedge clk);
    chk("rst_force", bus.match, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    feed(32'b11001, 5, 32'h10, "post_rst");
    idle();
    chk("post_rst_cnt", bus.match_cnt, 1);

`ifdef SEQ_DET_MASK_EN
    // Middle bit don't-care: both 101 and 111 match.
    load(8'b101, 3, 1'b1, 8'b101, 1'b0);
    feed(32'b10111, 5, 32'h14, "mask");
    idle();
    chk("mask_cnt", bus.match_cnt, 3);
`endif

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
